// File: rtl/quad_enc_if.sv
// Bundles the quadrature pins, counter controls and counter outputs.
// The master drives pins and controls; the slave is the counter.
interface quad_enc_if #(
  parameter int CNT_W = 8
);
  logic             a;
  logic             b;
  logic             clr;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             err_clr;
  logic [CNT_W-1:0] cnt;
  logic             dir;
  logic             step;
  logic             err;
  logic             err_flag;

  modport master (
    output a, b, clr, load, load_val, err_clr,
    input  cnt, dir, step, err, err_flag
  );

  modport slave (
    input  a, b, clr, load, load_val, err_clr,
    output cnt, dir, step, err, err_flag
  );
endinterface

// File: rtl/quad_enc_counter.sv
// Quadrature encoder counter: synchroniser, glitch filter, x1/x2/x4 decode,
// wrap/saturate, clear/load and illegal-transition detection.
//
// state      | meaning
// ST_ARMING  | filters track the pins directly, no decoding
// ST_RUN     | filtered A/B decoded every cycle
module quad_enc_counter #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int MODE        = 4,
  parameter int SATURATE    = 0
) (
  input logic        clk,
  input logic        rst_n,
  quad_enc_if.slave  bus
);

  localparam int ARM_CYC = SYNC_STAGES + FILT_LEN;
  localparam int ARM_W   = $clog2(ARM_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0]       FILT_TC = 4'(FILT_LEN - 1);

  typedef enum logic {ST_ARMING, ST_RUN} state_t;

  state_t                 state;
  logic [ARM_W-1:0]       arm_cnt;
  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic                   sa;
  logic                   sb;
  logic                   filt_a;
  logic                   filt_b;
  logic [3:0]             fcnt_a;
  logic [3:0]             fcnt_b;
  logic [1:0]             prev_ab;
  logic [1:0]             cur_ab;
  logic                   fwd;
  logic                   bwd;
  logic                   ill;
  logic                   qual;
  logic                   count_ev;
  logic [CNT_W-1:0]       cnt_inc;
  logic [CNT_W-1:0]       cnt_dec;
  logic [CNT_W-1:0]       cnt_q;
  logic                   dir_q;
  logic                   step_q;
  logic                   err_q;
  logic                   err_flag_q;

  assign sa = sync_a[SYNC_STAGES-1];
  assign sb = sync_b[SYNC_STAGES-1];

  assign bus.cnt      = cnt_q;
  assign bus.dir      = dir_q;
  assign bus.step     = step_q;
  assign bus.err      = err_q;
  assign bus.err_flag = err_flag_q;

  always_comb begin
    cur_ab = {filt_a, filt_b};
    fwd    = 1'b0;
    bwd    = 1'b0;
    case ({prev_ab, cur_ab})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd = 1'b1;
      4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: bwd = 1'b1;
      default: ;
    endcase
    ill = (cur_ab == ~prev_ab);
    case (MODE)
      4:       qual = 1'b1;
      2:       qual = prev_ab[1] ^ cur_ab[1];
      default: qual = (prev_ab == 2'b01 && cur_ab == 2'b00) ||
                      (prev_ab == 2'b00 && cur_ab == 2'b01);
    endcase
    count_ev = (state == ST_RUN) && (fwd || bwd) && qual;
    cnt_inc  = (SATURATE != 0 && cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    cnt_dec  = (SATURATE != 0 && cnt_q == '0)      ? cnt_q : cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_ARMING;
      arm_cnt    <= ARM_W'(ARM_CYC - 1);
      sync_a     <= '0;
      sync_b     <= '0;
      filt_a     <= 1'b0;
      filt_b     <= 1'b0;
      fcnt_a     <= '0;
      fcnt_b     <= '0;
      prev_ab    <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], bus.a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], bus.b};
      step_q <= 1'b0;
      err_q  <= 1'b0;
      // A new error below overrides this clear in the same cycle
      if (bus.err_clr) err_flag_q <= 1'b0;

      case (state)
        ST_ARMING: begin
          filt_a  <= sa;
          filt_b  <= sb;
          fcnt_a  <= '0;
          fcnt_b  <= '0;
          prev_ab <= {sa, sb};
          if (arm_cnt == '0) state <= ST_RUN;
          else               arm_cnt <= arm_cnt - 1'b1;
        end
        ST_RUN: begin
          if (sa == filt_a)          fcnt_a <= '0;
          else if (fcnt_a == FILT_TC) begin
            filt_a <= sa;
            fcnt_a <= '0;
          end else                   fcnt_a <= fcnt_a + 1'b1;

          if (sb == filt_b)          fcnt_b <= '0;
          else if (fcnt_b == FILT_TC) begin
            filt_b <= sb;
            fcnt_b <= '0;
          end else                   fcnt_b <= fcnt_b + 1'b1;

          prev_ab <= cur_ab;
          if (ill) begin
            err_q      <= 1'b1;
            err_flag_q <= 1'b1;
          end else if (fwd || bwd) begin
            dir_q <= fwd;
            if (qual) step_q <= 1'b1;
          end
        end
        default: state <= ST_ARMING;
      endcase

      if (bus.clr)       cnt_q <= '0;
      else if (bus.load) cnt_q <= bus.load_val;
      else if (count_ev) cnt_q <= fwd ? cnt_inc : cnt_dec;
    end
  end

endmodule
